aux_cmd_scheduler: RTL and testbench



---
 rtl/aux_cmd_scheduler.sv | 133 +++++++++++++
 tb/tb_aux_cmd_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_cmd_scheduler.sv
// aux_cmd_scheduler: time-shares the command RAM read port B between NUM_SLOTS
// auxiliary command slots. Each frame_start runs one fixed-length round that
// fetches one word per slot, advances each slot's index with wrap-to-loop, and
// ends with a one-cycle cmd_valid strobe.
module aux_cmd_scheduler #(
    parameter int unsigned NUM_SLOTS = 3,
    parameter logic [15:0] IDLE_CMD  = 16'h0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    index_reset,
    input  logic [NUM_SLOTS-1:0]    slot_enable,
    input  logic [4*NUM_SLOTS-1:0]  slot_bank,
    input  logic [10*NUM_SLOTS-1:0] slot_end,
    input  logic [10*NUM_SLOTS-1:0] slot_loop,
    output logic [3:0]              RAM_bank_sel_B,
    output logic [9:0]              RAM_addr_B,
    input  logic [15:0]             RAM_data_out_B,
    output logic [16*NUM_SLOTS-1:0] cmd_word,
    output logic                    cmd_valid,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clear,
    output logic [10*NUM_SLOTS-1:0] slot_index
);

    localparam int unsigned CntW = $clog2(NUM_SLOTS + 2);

    typedef enum logic {StIdle, StActive} state_t;

    state_t          state;
    logic [CntW-1:0] cnt;

    // Per-slot state: running index, captured word, and the configuration
    // latched at issue time so host writes mid-round cannot tear a capture.
    logic [9:0]  idx      [NUM_SLOTS];
    logic [15:0] cmd      [NUM_SLOTS];
    logic        lat_en   [NUM_SLOTS];
    logic [9:0]  lat_end  [NUM_SLOTS];
    logic [9:0]  lat_loop [NUM_SLOTS];

    // Round FSM: issue/capture schedule, index advance, strobes and overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= StIdle;
            cnt            <= '0;
            RAM_addr_B     <= '0;
            RAM_bank_sel_B <= '0;
            cmd_valid      <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                idx[s]      <= '0;
                cmd[s]      <= IDLE_CMD;
                lat_en[s]   <= 1'b0;
                lat_end[s]  <= '0;
                lat_loop[s] <= '0;
            end
        end else begin
            cmd_valid <= 1'b0;

            // A new overrun wins over a simultaneous clear.
            if (frame_start && busy) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (frame_start) begin
                        RAM_addr_B     <= idx[0];
                        RAM_bank_sel_B <= slot_bank[3:0];
                        lat_en[0]      <= slot_enable[0];
                        lat_end[0]     <= slot_end[9:0];
                        lat_loop[0]    <= slot_loop[9:0];
                        busy           <= 1'b1;
                        cnt            <= '0;
                        state          <= StActive;
                    end
                end
                StActive: begin
                    cnt <= cnt + CntW'(1);
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        // Issue slot cnt+1; disabled slots still take their cycle.
                        if (int'(cnt) + 1 == s) begin
                            RAM_addr_B     <= idx[s];
                            RAM_bank_sel_B <= slot_bank[4*s +: 4];
                            lat_en[s]      <= slot_enable[s];
                            lat_end[s]     <= slot_end[10*s +: 10];
                            lat_loop[s]    <= slot_loop[10*s +: 10];
                        end
                        // Capture slot cnt-1: its data left the RAM one edge ago.
                        if (int'(cnt) == s + 1) begin
                            if (lat_en[s]) begin
                                cmd[s] <= RAM_data_out_B;
                                idx[s] <= (idx[s] >= lat_end[s]) ? lat_loop[s]
                                                                 : idx[s] + 10'd1;
                            end else begin
                                cmd[s] <= IDLE_CMD;
                            end
                        end
                    end
                    if (cnt == CntW'(NUM_SLOTS)) begin
                        cmd_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Placed last so it overrides any advance on the same edge.
            if (index_reset) begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    idx[s] <= '0;
                end
            end
        end
    end

    // Flatten per-slot registers onto the packed output buses.
    always_comb begin
        cmd_word   = '0;
        slot_index = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            cmd_word[16*s +: 16]   = cmd[s];
            slot_index[10*s +: 10] = idx[s];
        end
    end

endmodule

// File: tb/tb_aux_cmd_scheduler.sv
// Directed bench for aux_cmd_scheduler with a behavioural registered-read RAM.
module tb_aux_cmd_scheduler;

    localparam int unsigned N        = 3;
    localparam logic [15:0] IDLE_CMD = 16'h0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          index_reset;
    logic [N-1:0]  slot_enable;
    logic [4*N-1:0]  slot_bank;
    logic [10*N-1:0] slot_end;
    logic [10*N-1:0] slot_loop;
    logic [3:0]    RAM_bank_sel_B;
    logic [9:0]    RAM_addr_B;
    logic [15:0]   RAM_data_out_B;
    logic [16*N-1:0] cmd_word;
    logic          cmd_valid;
    logic          busy;
    logic          overrun;
    logic          overrun_clear;
    logic [10*N-1:0] slot_index;

    int n_cmp = 0;
    int n_bad = 0;

    aux_cmd_scheduler #(.NUM_SLOTS(N), .IDLE_CMD(IDLE_CMD)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .index_reset    (index_reset),
        .slot_enable    (slot_enable),
        .slot_bank      (slot_bank),
        .slot_end       (slot_end),
        .slot_loop      (slot_loop),
        .RAM_bank_sel_B (RAM_bank_sel_B),
        .RAM_addr_B     (RAM_addr_B),
        .RAM_data_out_B (RAM_data_out_B),
        .cmd_word       (cmd_word),
        .cmd_valid      (cmd_valid),
        .busy           (busy),
        .overrun        (overrun),
        .overrun_clear  (overrun_clear),
        .slot_index     (slot_index)
    );

    always #5 clk = ~clk;

    // RAM contents: bank 2 words 0..3 hold A000..A003, else {bank, 01, addr}.
    function automatic logic [15:0] ram_word(input logic [3:0] b, input logic [9:0] a);
        if (b == 4'd2 && a < 10'd4) return 16'hA000 + {6'd0, a};
        return {b, 2'b01, a};
    endfunction

    always @(posedge clk) RAM_data_out_B <= ram_word(RAM_bank_sel_B, RAM_addr_B);

    task automatic pulse_index_reset();
        @(negedge clk) index_reset = 1'b1;
        @(negedge clk) index_reset = 1'b0;
    endtask

    // Pulse frame_start; lat = edges from E0 to the edge raising cmd_valid, -1 on timeout.
    task automatic run_round(output int lat);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        lat = 0;
        while (!cmd_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!cmd_valid) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; index_reset = 1'b0; overrun_clear = 1'b0;
        slot_enable = '0; slot_bank = '0; slot_end = '0; slot_loop = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (RAM_addr_B !== 10'd0) begin n_bad++;
            $display("FAIL reset_addr got %h want 0", RAM_addr_B); end
        n_cmp++; if (RAM_bank_sel_B !== 4'd0) begin n_bad++;
            $display("FAIL reset_bank got %h want 0", RAM_bank_sel_B); end
        n_cmp++; if (cmd_word !== {N{IDLE_CMD}}) begin n_bad++;
            $display("FAIL reset_cmd got %h want %h", cmd_word, {N{IDLE_CMD}}); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_valid got %b want 0", cmd_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++;
            $display("FAIL reset_overrun got %b want 0", overrun); end
        n_cmp++; if (slot_index !== '0) begin n_bad++;
            $display("FAIL reset_index got %h want 0", slot_index); end
    endtask

    task automatic test_loop_sequence();
        int exp_a [6] = '{0, 1, 2, 3, 1, 2};
        int lat;
        slot_enable = 3'b111;
        slot_bank   = {4'd5, 4'd7, 4'd2};
        slot_end    = {10'd1023, 10'd1023, 10'd3};
        slot_loop   = {10'd0, 10'd0, 10'd1};
        pulse_index_reset();
        for (int i = 0; i < 6; i++) begin
            run_round(lat);
            n_cmp++; if (lat !== 4) begin n_bad++;
                $display("FAIL loop_latency[%0d] got %0d want 4", i, lat); end
            n_cmp++; if (cmd_word[15:0] !== 16'hA000 + 16'(exp_a[i])) begin n_bad++;
                $display("FAIL loop_word[%0d] got %h want %h", i, cmd_word[15:0],
                         16'hA000 + 16'(exp_a[i])); end
            @(negedge clk);
            n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++;
                $display("FAIL loop_strobe_width[%0d] got %b want 0", i, cmd_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_disabled_slot();
        int waited = 0;
        slot_enable = 3'b101;
        slot_bank   = {4'd5, 4'd7, 4'd0};
        slot_end    = {10'd1023, 10'd1023, 10'd1023};
        slot_loop   = '0;
        pulse_index_reset();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        n_cmp++; if (RAM_bank_sel_B !== 4'd0) begin n_bad++;
            $display("FAIL dis_bank0 got %h want 0", RAM_bank_sel_B); end
        @(negedge clk);
        n_cmp++; if (RAM_bank_sel_B !== 4'd7) begin n_bad++;
            $display("FAIL dis_bank1 got %h want 7", RAM_bank_sel_B); end
        @(negedge clk);
        n_cmp++; if (RAM_bank_sel_B !== 4'd5) begin n_bad++;
            $display("FAIL dis_bank2 got %h want 5", RAM_bank_sel_B); end
        while (!cmd_valid && waited < 10) begin @(negedge clk); waited++; end
        n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++;
            $display("FAIL dis_valid got %b want 1", cmd_valid); end
        n_cmp++; if (cmd_word[31:16] !== IDLE_CMD) begin n_bad++;
            $display("FAIL dis_cmd1 got %h want %h", cmd_word[31:16], IDLE_CMD); end
        n_cmp++; if (slot_index[19:10] !== 10'd0) begin n_bad++;
            $display("FAIL dis_index1 got %0d want 0", slot_index[19:10]); end
        n_cmp++; if (cmd_word[15:0] !== 16'h0400) begin n_bad++;
            $display("FAIL dis_cmd0 got %h want 0400", cmd_word[15:0]); end
        n_cmp++; if (cmd_word[47:32] !== 16'h5400) begin n_bad++;
            $display("FAIL dis_cmd2 got %h want 5400", cmd_word[47:32]); end
        n_cmp++; if (slot_index[29:20] !== 10'd1) begin n_bad++;
            $display("FAIL dis_index2 got %0d want 1", slot_index[29:20]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun();
        int valids = 0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_bad++;
            $display("FAIL ovr_set got %b want 1", overrun); end
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid) valids++;
            @(negedge clk);
        end
        n_cmp++; if (valids !== 1) begin n_bad++;
            $display("FAIL ovr_valid_count got %0d want 1", valids); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++;
            $display("FAIL ovr_sticky got %b want 1", overrun); end
        overrun_clear = 1'b1;
        @(negedge clk) overrun_clear = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++;
            $display("FAIL ovr_clear got %b want 0", overrun); end
    endtask

    task automatic test_index_reset_capture();
        int lat;
        int waited = 0;
        slot_enable = 3'b001;
        slot_bank   = {4'd0, 4'd0, 4'd3};
        slot_end    = {10'd0, 10'd0, 10'd1023};
        slot_loop   = '0;
        pulse_index_reset();
        for (int i = 0; i < 7; i++) begin
            run_round(lat);
            repeat (2) @(negedge clk);
        end
        n_cmp++; if (slot_index[9:0] !== 10'd7) begin n_bad++;
            $display("FAIL ixr_pre got %0d want 7", slot_index[9:0]); end
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk) index_reset = 1'b1;   // high across E2, slot 0's capture edge
        @(negedge clk) index_reset = 1'b0;
        n_cmp++; if (slot_index[9:0] !== 10'd0) begin n_bad++;
            $display("FAIL ixr_index got %0d want 0", slot_index[9:0]); end
        while (!cmd_valid && waited < 10) begin @(negedge clk); waited++; end
        n_cmp++; if (cmd_word[15:0] !== 16'h3407) begin n_bad++;
            $display("FAIL ixr_word got %h want 3407", cmd_word[15:0]); end
        n_cmp++; if (slot_index[9:0] !== 10'd0) begin n_bad++;
            $display("FAIL ixr_index_after got %0d want 0", slot_index[9:0]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loop_gt_end();
        int exp_a [6] = '{0, 1, 2, 5, 5, 5};
        int exp_i [6] = '{1, 2, 5, 5, 5, 5};
        int lat;
        slot_enable = 3'b001;
        slot_bank   = {4'd0, 4'd0, 4'd4};
        slot_end    = {10'd0, 10'd0, 10'd2};
        slot_loop   = {10'd0, 10'd0, 10'd5};
        pulse_index_reset();
        for (int i = 0; i < 6; i++) begin
            run_round(lat);
            n_cmp++; if (cmd_word[15:0] !== ram_word(4'd4, 10'(exp_a[i]))) begin n_bad++;
                $display("FAIL park_word[%0d] got %h want %h", i, cmd_word[15:0],
                         ram_word(4'd4, 10'(exp_a[i]))); end
            n_cmp++; if (slot_index[9:0] !== 10'(exp_i[i])) begin n_bad++;
                $display("FAIL park_index[%0d] got %0d want %0d", i, slot_index[9:0],
                         exp_i[i]); end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_round();
        int valids = 0;
        int lat;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;         // held across E3
        @(negedge clk) reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || overrun !== 1'b0) begin n_bad++;
            $display("FAIL mid_flags got busy=%b valid=%b ovr=%b want 0 0 0",
                     busy, cmd_valid, overrun); end
        n_cmp++; if (RAM_addr_B !== 10'd0 || RAM_bank_sel_B !== 4'd0) begin n_bad++;
            $display("FAIL mid_ram got addr=%h bank=%h want 0 0", RAM_addr_B,
                     RAM_bank_sel_B); end
        n_cmp++; if (cmd_word !== {N{IDLE_CMD}} || slot_index !== '0) begin n_bad++;
            $display("FAIL mid_state got cmd=%h idx=%h want %h 0", cmd_word, slot_index,
                     {N{IDLE_CMD}}); end
        for (int i = 0; i < 8; i++) begin
            if (cmd_valid) valids++;
            @(negedge clk);
        end
        n_cmp++; if (valids !== 0) begin n_bad++;
            $display("FAIL mid_no_valid got %0d want 0", valids); end
        slot_end  = {10'd0, 10'd0, 10'd1023};
        slot_loop = '0;
        run_round(lat);
        n_cmp++; if (lat !== 4) begin n_bad++;
            $display("FAIL mid_next_latency got %0d want 4", lat); end
        n_cmp++; if (cmd_word[15:0] !== 16'h4400) begin n_bad++;
            $display("FAIL mid_next_word got %h want 4400", cmd_word[15:0]); end
        n_cmp++; if (slot_index[9:0] !== 10'd1) begin n_bad++;
            $display("FAIL mid_next_index got %0d want 1", slot_index[9:0]); end
    endtask

    initial begin
        test_reset();
        test_loop_sequence();
        test_disabled_slot();
        test_overrun();
        test_index_reset_capture();
        test_loop_gt_end();
        test_reset_mid_round();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
